// File: rtl/bus_mailbox_pkg.sv
// Shared definitions for the bus mailbox: width helpers for the channel id and
// the {chan, data} queue entry, plus the default build parameters.
package bus_mailbox_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_CHANNELS = 4;
    localparam int DEF_DEPTH    = 4;

    // Ceiling log2 that never returns 0, so a 1-bit id or pointer still exists.
    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int cid_w(input int channels);
        return clog2_min1(channels);
    endfunction

    // Queue entry layout is {chan[CIDW-1:0], data[WIDTH-1:0]}.
    function automatic int entry_w(input int channels, input int width);
        return cid_w(channels) + width;
    endfunction

endpackage

// File: rtl/bus_mailbox_mux_if.sv
// Producer/consumer signal bundle of the mailbox mux; master is the
// surrounding system, slave is the mailbox itself.
interface bus_mailbox_mux_if
    import bus_mailbox_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int DEPTH    = DEF_DEPTH
);
    localparam int CIDW = cid_w(CHANNELS);
    localparam int LVLW = $clog2(DEPTH) + 1;

    logic [CHANNELS-1:0]       flag_in;
    logic [CHANNELS*WIDTH-1:0] bus_in;
    logic [CHANNELS-1:0]       busy;
    logic                      flag_out;
    logic                      ack_in;
    logic [WIDTH-1:0]          bus_out;
    logic [CIDW-1:0]           chan_out;
    logic [LVLW-1:0]           level;
    logic [CHANNELS-1:0]       drop_err;
    logic                      clr_err;

    modport master (
        output flag_in, bus_in, ack_in, clr_err,
        input  busy, flag_out, bus_out, chan_out, level, drop_err
    );

    modport slave (
        input  flag_in, bus_in, ack_in, clr_err,
        output busy, flag_out, bus_out, chan_out, level, drop_err
    );

endinterface

// File: rtl/bus_mailbox_fifo.sv
// Single-clock first-word-fall-through FIFO; the head is readable
// combinationally whenever the FIFO is not empty.
module bus_mailbox_fifo
    import bus_mailbox_pkg::*;
#(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push,
    input  logic [W-1:0]           wdata,
    input  logic                   pop,
    output logic [W-1:0]           rdata,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);
    localparam int AW   = clog2_min1(DEPTH);
    localparam int LVLW = $clog2(DEPTH) + 1;

    logic [W-1:0]    mem [DEPTH];
    logic [AW-1:0]   wrPtr;
    logic [AW-1:0]   rdPtr;
    logic [LVLW-1:0] count;
    logic            doPush;
    logic            doPop;

    assign empty  = (count == '0);
    assign full   = (count == LVLW'(DEPTH));
    assign doPop  = pop & ~empty;
    assign doPush = push & (~full | doPop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + AW'(1);
            if (doPop)  rdPtr <= rdPtr + AW'(1);
            case ({doPush, doPop})
                2'b10:   count <= count + LVLW'(1);
                2'b01:   count <= count - LVLW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only; emptiness is tracked by count.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= wdata;
    end

    assign rdata = empty ? '0 : mem[rdPtr];
    assign level = count;

endmodule

// File: rtl/bus_mailbox_mux.sv
// Multi-channel mailbox: per-channel holding registers merged round-robin into
// a FWFT queue that drains to a single consumer, each word tagged with its channel.
module bus_mailbox_mux
    import bus_mailbox_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int DEPTH    = DEF_DEPTH
) (
    input logic               clk,
    input logic               rstn,
    bus_mailbox_mux_if.slave  mbx
);
    localparam int CIDW    = cid_w(CHANNELS);
    localparam int ENTRY_W = entry_w(CHANNELS, WIDTH);
    localparam int LVLW    = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0]    hold [CHANNELS];
    logic [CHANNELS-1:0] busyQ;
    logic [CHANNELS-1:0] dropErr;
    logic [CIDW-1:0]     lastGrant;

    logic [CIDW-1:0]     grantIdx;
    logic                grantFound;
    logic                grant;
    logic                pop;
    logic [CHANNELS-1:0] freeMask;
    logic [CHANNELS-1:0] captureMask;
    logic [CHANNELS-1:0] dropMask;

    logic [ENTRY_W-1:0]  fifoRdata;
    logic [LVLW-1:0]     fifoLevel;
    logic                fifoFull;
    logic                fifoEmpty;

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        int idx;
        idx        = 0;
        grantIdx   = '0;
        grantFound = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            idx = (int'(lastGrant) + 1 + k) % CHANNELS;
            if (!grantFound && busyQ[idx]) begin
                grantFound = 1'b1;
                grantIdx   = CIDW'(idx);
            end
        end
    end

    assign pop   = ~fifoEmpty & mbx.ack_in;
    assign grant = grantFound & (~fifoFull | pop);

    // A channel released by this cycle's grant may capture on the same edge.
    assign freeMask    = grant ? (CHANNELS'(1) << grantIdx) : '0;
    assign captureMask = mbx.flag_in & (~busyQ | freeMask);
    assign dropMask    = mbx.flag_in & busyQ & ~freeMask;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busyQ     <= '0;
            dropErr   <= '0;
            lastGrant <= CIDW'(CHANNELS - 1);
            for (int i = 0; i < CHANNELS; i++) hold[i] <= '0;
        end else begin
            busyQ   <= (busyQ & ~freeMask) | captureMask;
            dropErr <= (mbx.clr_err ? '0 : dropErr) | dropMask;
            if (grant) lastGrant <= grantIdx;
            for (int i = 0; i < CHANNELS; i++) begin
                if (captureMask[i]) hold[i] <= mbx.bus_in[i*WIDTH +: WIDTH];
            end
        end
    end

    bus_mailbox_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) uFifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (grant),
        .wdata ({grantIdx, hold[grantIdx]}),
        .pop   (pop),
        .rdata (fifoRdata),
        .level (fifoLevel),
        .full  (fifoFull),
        .empty (fifoEmpty)
    );

    assign mbx.busy     = busyQ;
    assign mbx.drop_err = dropErr;
    assign mbx.flag_out = ~fifoEmpty;
    assign mbx.bus_out  = fifoRdata[WIDTH-1:0];
    assign mbx.chan_out = fifoRdata[ENTRY_W-1:WIDTH];
    assign mbx.level    = fifoLevel;

endmodule

// File: tb/tb_bus_mailbox_mux.sv
// Directed bench for bus_mailbox_mux: stimulus pushes expected {chan,data}
// words into a scoreboard queue, a negedge monitor pops and compares on each accepted head.
module tb_bus_mailbox_mux;
    import bus_mailbox_pkg::*;

    localparam int W  = 8;
    localparam int CH = 4;
    localparam int D  = 4;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    bus_mailbox_mux_if #(.WIDTH(W), .CHANNELS(CH), .DEPTH(D)) mbx ();

    bus_mailbox_mux #(.WIDTH(W), .CHANNELS(CH), .DEPTH(D)) dut (
        .clk  (clk),
        .rstn (rstn),
        .mbx  (mbx)
    );

    int vectors     = 0;
    int miscompares = 0;
    logic [9:0] expQ [$];
    logic [9:0] headExp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setBus(input int ch, input logic [7:0] d);
        mbx.bus_in[ch*W +: W] = d;
    endtask

    task automatic pushExp(input int ch, input logic [7:0] d);
        expQ.push_back({2'(ch), d});
    endtask

    task automatic chkResetOutputs(input string tag);
        chk({tag, "_busy"},     mbx.busy,     0);
        chk({tag, "_flag_out"}, mbx.flag_out, 0);
        chk({tag, "_bus_out"},  mbx.bus_out,  0);
        chk({tag, "_chan_out"}, mbx.chan_out, 0);
        chk({tag, "_level"},    mbx.level,    0);
        chk({tag, "_drop_err"}, mbx.drop_err, 0);
    endtask

    task automatic doReset();
        rstn = 1'b0;
        expQ.delete();
        #1;
        chkResetOutputs("reset");
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 30; i++) begin
            if (mbx.level == 0 && mbx.busy == 0) break;
            tick();
        end
        chk({tag, "_drained_level"}, mbx.level, 0);
        chk({tag, "_drained_busy"},  mbx.busy,  0);
    endtask

    // Scoreboard monitor: a word is consumed on the edge following a negedge
    // where the head is valid and acknowledged.
    always @(negedge clk) begin
        if (rstn && mbx.flag_out && mbx.ack_in) begin
            vectors++;
            if (expQ.size() == 0) begin
                miscompares++;
                $display("FAIL head_word: got ch%0d data %02h, expected no word",
                         mbx.chan_out, mbx.bus_out);
            end else begin
                headExp = expQ.pop_front();
                if ({mbx.chan_out, mbx.bus_out} !== headExp) begin
                    miscompares++;
                    $display("FAIL head_word: got ch%0d data %02h, expected ch%0d data %02h",
                             mbx.chan_out, mbx.bus_out, headExp[9:8], headExp[7:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn        = 1'b0;
        mbx.flag_in = '0;
        mbx.bus_in  = '0;
        mbx.ack_in  = 1'b0;
        mbx.clr_err = 1'b0;
        #3;
        chkResetOutputs("init");
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Single flag on ch1
        mbx.ack_in = 1'b1;
        setBus(1, 8'hA5);
        mbx.flag_in = 4'b0010;
        pushExp(1, 8'hA5);
        tick();
        mbx.flag_in = '0;
        chk("t1_busy_set", mbx.busy, 4'b0010);
        chk("t1_head_not_yet", mbx.flag_out, 0);
        tick();
        chk("t1_busy_clear", mbx.busy, 0);
        chk("t1_head_valid", mbx.flag_out, 1);
        chk("t1_level", mbx.level, 1);
        chk("t1_bus_out", mbx.bus_out, 8'hA5);
        chk("t1_chan_out", mbx.chan_out, 1);
        tick();
        chk("t1_head_gone", mbx.flag_out, 0);
        chk("t1_level_zero", mbx.level, 0);
        tick();
        chk("t1_empty_ack_level", mbx.level, 0);

        // Fairness from a fresh pointer
        doReset();
        setBus(0, 8'h10); setBus(1, 8'h11); setBus(2, 8'h12); setBus(3, 8'h13);
        mbx.flag_in = 4'b1111;
        pushExp(0, 8'h10); pushExp(1, 8'h11); pushExp(2, 8'h12); pushExp(3, 8'h13);
        tick();
        mbx.flag_in = '0;
        chk("t2_all_busy", mbx.busy, 4'b1111);
        for (int i = 0; i < 5; i++) tick();
        setBus(0, 8'h20); setBus(3, 8'h30);
        mbx.flag_in = 4'b1001;
        pushExp(0, 8'h20); pushExp(3, 8'h30);
        tick();
        mbx.flag_in = '0;
        drain("t2");

        // Backpressure: six flags, queue saturates
        mbx.ack_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            setBus(i % 4, 8'(8'h40 + i));
            mbx.flag_in = 4'(1 << (i % 4));
            pushExp(i % 4, 8'(8'h40 + i));
            tick();
        end
        mbx.flag_in = '0;
        chk("t3_level_full", mbx.level, 4);
        chk("t3_busy_pending", mbx.busy, 4'b0011);
        chk("t3_head_data", mbx.bus_out, 8'h40);

        // Simultaneous push and pop while full
        mbx.ack_in = 1'b1;
        tick();
        mbx.ack_in = 1'b0;
        chk("t4_level_stays", mbx.level, 4);
        chk("t4_busy_ch0_cleared", mbx.busy, 4'b0010);
        chk("t4_head_advanced", mbx.bus_out, 8'h41);
        chk("t4_head_chan", mbx.chan_out, 1);

        // Drop and clear on ch2 while full
        setBus(2, 8'h52);
        mbx.flag_in = 4'b0100;
        pushExp(2, 8'h52);
        tick();
        setBus(2, 8'h62);
        tick();
        mbx.flag_in = '0;
        chk("t5_drop_set", mbx.drop_err, 4'b0100);
        chk("t5_busy", mbx.busy, 4'b0110);
        mbx.clr_err = 1'b1;
        tick();
        mbx.clr_err = 1'b0;
        chk("t5_drop_cleared", mbx.drop_err, 0);
        mbx.clr_err = 1'b1;
        setBus(2, 8'h72);
        mbx.flag_in = 4'b0100;
        tick();
        mbx.clr_err = 1'b0;
        mbx.flag_in = '0;
        chk("t5_set_beats_clear", mbx.drop_err, 4'b0100);
        mbx.ack_in = 1'b1;
        drain("t5");
        mbx.ack_in = 1'b0;
        mbx.clr_err = 1'b1;
        tick();
        mbx.clr_err = 1'b0;
        chk("t5_final_clear", mbx.drop_err, 0);

        // Build level=3, busy=1010 and reset asynchronously
        setBus(0, 8'h70); mbx.flag_in = 4'b0001; tick();
        setBus(1, 8'h71); mbx.flag_in = 4'b0010; tick();
        setBus(2, 8'h72); mbx.flag_in = 4'b0100; tick();
        setBus(1, 8'h81); setBus(3, 8'h83); mbx.flag_in = 4'b1010; tick();
        mbx.flag_in = '0;
        chk("t6_level_pre", mbx.level, 3);
        chk("t6_busy_pre", mbx.busy, 4'b1010);
        #2;
        rstn = 1'b0;
        #1;
        chkResetOutputs("t6_async");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        mbx.ack_in = 1'b1;
        setBus(0, 8'h90); setBus(3, 8'h93);
        mbx.flag_in = 4'b1001;
        pushExp(0, 8'h90); pushExp(3, 8'h93);
        tick();
        mbx.flag_in = '0;
        drain("t6");
        for (int i = 0; i < 3; i++) tick();
        chk("t6_no_replay", mbx.flag_out, 0);
        chk("scoreboard_empty", expQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
